// File: rtl/msx_mouse_pkg.sv
// Shared types and helpers for the MSX mouse port: nibble sequencer states
// and the mapping from sequencer state to the nibble shown on the port.
package msx_mouse_pkg;

   typedef enum logic [1:0] {
      S_XH = 2'd0,
      S_XL = 2'd1,
      S_YH = 2'd2,
      S_YL = 2'd3
   } seq_state_t;

   localparam logic [5:0] PORT_IDLE = 6'h3F;
   localparam int         NIB_HI    = 4;
   localparam int         NIB_LO    = 0;

   function automatic seq_state_t next_state(input seq_state_t s);
      case (s)
         S_XH:    return S_XL;
         S_XL:    return S_YH;
         S_YH:    return S_YL;
         default: return S_XH;
      endcase
   endfunction

   function automatic logic [3:0] sel_nibble(input seq_state_t s,
                                             input logic [7:0] x,
                                             input logic [7:0] y);
      case (s)
         S_XH:    return x[NIB_HI +: 4];
         S_XL:    return x[NIB_LO +: 4];
         S_YH:    return y[NIB_HI +: 4];
         default: return y[NIB_LO +: 4];
      endcase
   endfunction

endpackage

// File: rtl/msx_sat_acc.sv
// One mouse axis: signed saturating accumulator with optional delta negation
// and a clear that can coincide with a new delta.
module msx_sat_acc #(
   parameter int DELTA_W = 9,
   parameter int ACC_W   = 8,
   parameter int INVERT  = 0
) (
   input  logic                      clk_sys,
   input  logic                      reset_n,
   input  logic                      i_add,
   input  logic                      i_clear,
   input  logic signed [DELTA_W-1:0] i_delta,
   output logic signed [ACC_W-1:0]   o_acc
);

   localparam int EXT_W = ACC_W + 1;
   localparam int SUM_W = ACC_W + 2;
   localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(-(2 ** (ACC_W - 1)));

   logic signed [DELTA_W:0]   w_wide;
   logic signed [DELTA_W:0]   w_neg;
   logic signed [EXT_W-1:0]   w_ext;
   logic signed [SUM_W-1:0]   w_base;
   logic signed [SUM_W-1:0]   w_sum;
   logic signed [ACC_W-1:0]   w_sat;
   logic signed [ACC_W-1:0]   r_acc;

   // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
   always_comb begin
      w_wide = {i_delta[DELTA_W-1], i_delta};
      w_neg  = (INVERT != 0) ? -w_wide : w_wide;
      w_ext  = EXT_W'(w_neg);
      w_base = i_clear ? SUM_W'(0) : SUM_W'(r_acc);
      w_sum  = w_base + SUM_W'(w_ext);
      if (w_sum > ACC_MAX)
         w_sat = ACC_W'(ACC_MAX);
      else if (w_sum < ACC_MIN)
         w_sat = ACC_W'(ACC_MIN);
      else
         w_sat = ACC_W'(w_sum);
   end

   // A clear coinciding with an add loads the new delta alone (w_base is zero).
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         r_acc <= '0;
      else if (i_add)
         r_acc <= w_sat;
      else if (i_clear)
         r_acc <= '0;
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/msx_mouse_port.sv
// MSX general-purpose port emulation: host mouse deltas served as four nibbles
// per stb toggle sequence, with joystick passthrough when the mouse is idle.
module msx_mouse_port
   import msx_mouse_pkg::*;
#(
   parameter int DELTA_W  = 9,
   parameter int ACC_W    = 8,
   parameter int TIMEOUT  = 100000,
   parameter int INVERT_X = 1
) (
   input  logic                      clk_sys,
   input  logic                      reset_n,
   input  logic signed [DELTA_W-1:0] mouse_x,
   input  logic signed [DELTA_W-1:0] mouse_y,
   input  logic [1:0]                mouse_btn,
   input  logic                      mouse_strobe,
   input  logic [5:0]                joy_n,
   input  logic                      stb,
   output logic [5:0]                port_out,
   output logic                      mouse_active
);

   localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   seq_state_t              r_state;
   logic                    r_stb;
   logic [TO_W-1:0]         r_timeout;
   logic [7:0]              r_snap_x;
   logic [7:0]              r_snap_y;
   logic [5:0]              r_port_out;
   logic                    r_mouse_active;

   logic                    w_edge;
   logic                    w_snap_edge;
   logic                    w_deact;
   logic                    w_acc_clear;
   logic signed [ACC_W-1:0] w_acc_x;
   logic signed [ACC_W-1:0] w_acc_y;
   logic [7:0]              w_cur_x;
   logic [3:0]              w_nibble;

   assign w_edge      = stb ^ r_stb;
   assign w_snap_edge = w_edge && r_mouse_active && (r_state == S_XH);
   assign w_deact     = r_mouse_active && !mouse_strobe && (joy_n != PORT_IDLE);
   assign w_acc_clear = w_snap_edge || w_deact;
   // The S_XH nibble comes from the value being snapshotted on this same edge.
   assign w_cur_x     = (r_state == S_XH) ? w_acc_x[7:0] : r_snap_x;
   assign w_nibble    = sel_nibble(r_state, w_cur_x, r_snap_y);

   msx_sat_acc #(.DELTA_W(DELTA_W), .ACC_W(ACC_W), .INVERT(INVERT_X)) u_acc_x (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .i_add   (mouse_strobe),
      .i_clear (w_acc_clear),
      .i_delta (mouse_x),
      .o_acc   (w_acc_x)
   );

   msx_sat_acc #(.DELTA_W(DELTA_W), .ACC_W(ACC_W), .INVERT(0)) u_acc_y (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .i_add   (mouse_strobe),
      .i_clear (w_acc_clear),
      .i_delta (mouse_y),
      .o_acc   (w_acc_y)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_XH;
         r_stb          <= 1'b0;
         r_timeout      <= '0;
         r_snap_x       <= '0;
         r_snap_y       <= '0;
         r_port_out     <= PORT_IDLE;
         r_mouse_active <= 1'b0;
      end else begin
         r_stb <= stb;

         if (w_edge)
            r_timeout <= TO_W'(TIMEOUT);
         else if (r_timeout != '0)
            r_timeout <= r_timeout - 1'b1;

         // Sequencer only runs in mouse mode; an edge beats a simultaneous timeout.
         if (w_deact || !r_mouse_active) begin
            r_state <= S_XH;
         end else if (w_edge) begin
            if (r_state == S_XH) begin
               r_snap_x <= w_acc_x[7:0];
               r_snap_y <= w_acc_y[7:0];
            end
            r_state <= next_state(r_state);
         end else if (r_timeout == TO_W'(1)) begin
            r_state <= S_XH;
         end

         if (mouse_strobe)
            r_mouse_active <= 1'b1;
         else if (joy_n != PORT_IDLE)
            r_mouse_active <= 1'b0;

         if (r_mouse_active) begin
            r_port_out[5:4] <= ~mouse_btn;
            if (w_edge)
               r_port_out[3:0] <= w_nibble;
         end else begin
            r_port_out <= stb ? PORT_IDLE : joy_n;
         end
      end
   end

   assign port_out     = r_port_out;
   assign mouse_active = r_mouse_active;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Scoreboard bench for msx_mouse_port: expected nibbles are queued as deltas are
// driven and compared against port_out after each stb toggle.
module tb_msx_mouse_port;

   localparam int DELTA_W = 9;
   localparam int ACC_W   = 8;
   localparam int TIMEOUT = 20;

   logic                      clk_sys = 1'b0;
   logic                      reset_n;
   logic signed [DELTA_W-1:0] mouse_x;
   logic signed [DELTA_W-1:0] mouse_y;
   logic [1:0]                mouse_btn;
   logic                      mouse_strobe;
   logic [5:0]                joy_n;
   logic                      stb;
   logic [5:0]                port_out;
   logic                      mouse_active;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_q[$];

   msx_mouse_port #(
      .DELTA_W  (DELTA_W),
      .ACC_W    (ACC_W),
      .TIMEOUT  (TIMEOUT),
      .INVERT_X (1)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .mouse_x      (mouse_x),
      .mouse_y      (mouse_y),
      .mouse_btn    (mouse_btn),
      .mouse_strobe (mouse_strobe),
      .joy_n        (joy_n),
      .stb          (stb),
      .port_out     (port_out),
      .mouse_active (mouse_active)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input int x, input int y);
      mouse_x      = DELTA_W'(x);
      mouse_y      = DELTA_W'(y);
      mouse_strobe = 1'b1;
      tick();
      mouse_strobe = 1'b0;
      mouse_x      = '0;
      mouse_y      = '0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
   endtask

   task automatic edge_chk(input string tag);
      logic [3:0] exp_nib;
      stb = ~stb;
      tick();
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got %h expected <empty scoreboard>", tag, port_out[3:0]);
      end else begin
         exp_nib = exp_q.pop_front();
         check(tag, {4'h0, port_out[3:0]}, {4'h0, exp_nib});
      end
   endtask

   task automatic read_seq(input string tag, input logic [7:0] x, input logic [7:0] y);
      push_byte(x);
      push_byte(y);
      for (int i = 0; i < 4; i++)
         edge_chk($sformatf("%s_n%0d", tag, i));
   endtask

   initial begin
      reset_n      = 1'b0;
      mouse_x      = '0;
      mouse_y      = '0;
      mouse_btn    = 2'b00;
      mouse_strobe = 1'b0;
      joy_n        = 6'h3F;
      stb          = 1'b0;

      repeat (3) tick();
      check("rst_port", {2'b00, port_out}, 8'h3F);
      check("rst_active", {7'd0, mouse_active}, 8'h00);
      reset_n = 1'b1;
      tick();

      // +5/-3 with X inverted gives FB / FD
      strobe(5, -3);
      check("active_set", {7'd0, mouse_active}, 8'h01);
      mouse_btn = 2'b01;
      tick();
      check("buttons", {6'd0, port_out[5:4]}, 8'h02);
      mouse_btn = 2'b00;
      read_seq("basic", 8'hFB, 8'hFD);

      // Saturation at both rails
      repeat (10) strobe(-100, -100);
      read_seq("sat_pos", 8'h7F, 8'h80);
      repeat (10) strobe(100, 100);
      read_seq("sat_mix", 8'h80, 8'h7F);

      // Delta coinciding with the snapshot edge
      strobe(-16, 0);
      push_byte(8'h10);
      push_byte(8'h00);
      mouse_x      = DELTA_W'(-2);
      mouse_y      = '0;
      mouse_strobe = 1'b1;
      edge_chk("coinc_n0");
      mouse_strobe = 1'b0;
      mouse_x      = '0;
      for (int i = 1; i < 4; i++)
         edge_chk($sformatf("coinc_n%0d", i));
      read_seq("coinc_after", 8'h02, 8'h00);

      // Short idle keeps the sequence position
      strobe(-33, 71);
      push_byte(8'h21);
      edge_chk("short_xh");
      edge_chk("short_xl");
      repeat (TIMEOUT - 5) tick();
      push_byte(8'h47);
      edge_chk("short_yh");
      edge_chk("short_yl");

      // Timeout forces the sequence back to S_XH
      strobe(-32, 5);
      push_byte(8'h20);
      edge_chk("to_xh");
      edge_chk("to_xl");
      strobe(-52, 0);
      repeat (TIMEOUT + 1) tick();
      read_seq("to_fresh", 8'h34, 8'h00);

      // Joystick takeover clears accumulators
      strobe(-17, -34);
      joy_n = 6'h3E;
      tick();
      check("deact", {7'd0, mouse_active}, 8'h00);
      stb = 1'b1;
      tick();
      check("joy_stb1", {2'b00, port_out}, 8'h3F);
      stb = 1'b0;
      tick();
      check("joy_stb0", {2'b00, port_out}, 8'h3E);
      joy_n = 6'h3F;
      tick();
      check("joy_idle", {2'b00, port_out}, 8'h3F);
      strobe(0, 0);
      read_seq("cleared", 8'h00, 8'h00);

      // Reset mid-sequence (S_YH)
      strobe(-18, 52);
      push_byte(8'h12);
      edge_chk("pre_rst_xh");
      edge_chk("pre_rst_xl");
      reset_n = 1'b0;
      stb     = 1'b0;
      #1;
      check("rst_mid_port", {2'b00, port_out}, 8'h3F);
      check("rst_mid_active", {7'd0, mouse_active}, 8'h00);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      strobe(-86, 120);
      read_seq("post_rst", 8'h56, 8'h78);

      check("sb_empty", 8'(exp_q.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/msx_mouse_port.md
MSX_MOUSE_PORT -- requirements
Module: msx_mouse_port

Interface
REQ-001 SHALL have parameter DELTA_W, default 9: width of signed host mouse delta.
REQ-002 SHALL have parameter ACC_W, default 8: width of signed per-axis accumulator; minimum 8.
REQ-003 SHALL have parameter TIMEOUT, default 100000: idle clk_sys cycles after the last stb edge before the nibble sequence resets.
REQ-004 SHALL have parameter INVERT_X, default 1: when 1, X delta is negated before accumulation.
REQ-005 SHALL have ports: clk_sys  in  1  system clock.
REQ-006 SHALL have ports: reset_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports: mouse_x  in  DELTA_W  signed X delta from host.
REQ-008 SHALL have ports: mouse_y  in  DELTA_W  signed Y delta from host.
REQ-009 SHALL have ports: mouse_btn  in  2  buttons, active-high; bit0 left, bit1 right.
REQ-010 SHALL have ports: mouse_strobe  in  1  one-cycle pulse; deltas valid.
REQ-011 SHALL have ports: joy_n  in  6  joystick, active-low; [3:0] up,down,left,right; [5:4] trig A,B.
REQ-012 SHALL have ports: stb  in  1  MSX port strobe (pin 8), synchronous to clk_sys.
REQ-013 SHALL have ports: port_out  out  6  pin levels to MSX PSG port; registered.
REQ-014 SHALL have ports: mouse_active  out  1  1 = mouse protocol mode, 0 = joystick passthrough.

Function
REQ-015 SHALL, on mouse_strobe, add the delta (X negated if INVERT_X) sign-extended or truncated to ACC_W+1 bits into each axis accumulator, saturating at +(2^(ACC_W-1)-1) and -2^(ACC_W-1).
REQ-016 SHALL detect an stb edge when stb differs from its value registered on the previous cycle; either polarity counts.
REQ-017 SHALL run a 4-state sequencer S_XH, S_XL, S_YH, S_YL, advancing one state per stb edge and wrapping S_YL -> S_XH.
REQ-018 SHALL, on an edge in S_XH, snapshot both accumulators' low 8 bits into read registers and clear the accumulators.
REQ-019 SHALL, when mouse_strobe coincides with the S_XH snapshot edge, snapshot pre-add values and load accumulators with the new delta alone (saturated).
REQ-020 SHALL drive nibble on the edge cycle: S_XH -> X[7:4], S_XL -> X[3:0], S_YH -> Y[7:4], S_YL -> Y[3:0] of the snapshot, bit3 on port_out[3]; latency 1 clock from the sampled edge.
REQ-021 SHALL load a timeout counter with TIMEOUT on every stb edge, decrement it when non-zero, and force state S_XH when it transitions 1 -> 0; an edge in that same cycle takes priority.
REQ-022 SHALL, in mouse mode, drive port_out[5:4] = ~mouse_btn registered every cycle.
REQ-023 SHALL, in joystick mode, drive port_out = 6'h3F when stb is 1, else joy_n.
REQ-024 SHALL set mouse_active on mouse_strobe; clear it when any joy_n bit is 0 and mouse_strobe is 0; mouse_strobe wins on coincidence.
REQ-025 SHALL, on mouse_active 1 -> 0, clear accumulators and return sequencer to S_XH.

Reset
REQ-026 SHALL, while reset_n is 0, hold port_out = 6'h3F, mouse_active = 0, state S_XH, accumulators, snapshots and timeout = 0, stb register = 0.
REQ-027 SHALL abandon any in-progress sequence on reset; first edge after release is treated as S_XH.

Structure
REQ-028 SHALL place the sequencer state enum and nibble-select constants in package msx_mouse_pkg.
REQ-029 SHALL implement each axis with one sub-module msx_sat_acc (signed add, saturate, clear), instantiated twice.
REQ-030 SHALL contain no tri-states; open-collector emulation stays in the instantiating top level.

Verification
REQ-031 SHALL check: mouse_strobe x=+5, y=-3 (INVERT_X=1), then 4 stb toggles -> port_out[3:0] = F, B, F, D.
REQ-032 SHALL check: ten strobes x=-100 -> X snapshot = +127 (7F), nibbles 7 then F.
REQ-033 SHALL check: two stb toggles then TIMEOUT+1 idle cycles, next toggle -> state S_XH, fresh snapshot.
REQ-034 SHALL check: mouse_strobe x=-2 same cycle as S_XH edge with accumulator 0x10 -> snapshot X=0x10, accumulator afterwards = 2.
REQ-035 SHALL check: mouse active, joy_n = 6'h3E, no strobe -> mouse_active 0 next cycle; stb=1 -> port_out 3F; stb=0 -> 3E.
REQ-036 SHALL check: reset_n asserted mid-sequence (state S_YH) -> port_out 3F immediately, mouse_active 0, state S_XH after release.
